// File: rtl/avst_pkt_monitor_if.sv
// -----------------------------------------------------------------------------
// avst_pkt_monitor_if
//   Avalon-ST stream bundle (valid/ready handshake plus one packet line).
//
//   Parameters
//     DATA_W   data bus width in bits (multiple of 8)
//     EMPTY_W  empty field width, clog2(DATA_W/8)
//
//   Signals
//     valid        source -> sink  beat present on line
//     ready        sink -> source  sink can take a beat this edge
//     line.data    source -> sink  payload
//     line.sop     source -> sink  first beat of packet
//     line.eop     source -> sink  last beat of packet
//     line.empty   source -> sink  unused bytes in the eop beat
//
//   Modports
//     master  drives valid/line, samples ready (stream source)
//     slave   samples valid/line, drives ready (stream sink)
// -----------------------------------------------------------------------------
interface avst_pkt_monitor_if #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } line_t;

  logic  valid;
  logic  ready;
  line_t line;

  modport master (output valid, output line, input ready);
  modport slave  (input valid, input line, output ready);

endinterface

// File: rtl/avst_pkt_monitor.sv
// -----------------------------------------------------------------------------
// avst_pkt_monitor
//   Avalon-ST ingress stage. Registers the stream through a 2-entry skid
//   buffer, enforces SOP/EOP framing (malformed beats are dropped) and keeps
//   saturating packet / error statistics plus a wrapping byte count.
//
//   Optional feature (compile-time macro PKT_LEN_CHECK_EN):
//     packets longer than MAX_BEATS beats are truncated with a forced EOP on
//     the MAX_BEATS-th beat; the rest of the packet is discarded up to and
//     including its EOP, and len_err_cnt counts such packets. Without the
//     macro packets of any length pass and len_err_cnt is tied to zero.
//
//   Ports
//     sys_clk      in   single clock, rising edge
//     reset_n      in   asynchronous active-low reset
//     in           stream sink (slave modport)
//     out          stream source (master modport), fully registered
//     pkt_cnt      out  packets forwarded (EOP beats sent on out), saturating
//     byte_cnt     out  bytes forwarded, wraps modulo 2^BYTE_W
//     err_cnt      out  framing errors, saturating
//     len_err_cnt  out  over-length packets, saturating (0 without the macro)
// -----------------------------------------------------------------------------
module avst_pkt_monitor #(
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CNT_W     = 32,
  parameter int BYTE_W    = 48,
  parameter int MAX_BEATS = 24
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  avst_pkt_monitor_if.slave    in,
  avst_pkt_monitor_if.master   out,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [BYTE_W-1:0]    byte_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     len_err_cnt
);

  localparam int BYTES = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } line_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN_PKT
`ifdef PKT_LEN_CHECK_EN
    , S_DISCARD
`endif
  } state_t;

  state_t state_q, state_d;

  // Skid buffer: out_q is the presented beat, skid_q catches one more beat
  // so in.ready can be a pure register.
  line_t out_q, skid_q, push_line, beat_in;
  logic  out_valid_q, skid_valid_q, ready_q;
  logic  accept, pop, fwd, err_inc, eop_eff;
  logic [1:0] occ_d;

  logic [CNT_W-1:0]  pkt_cnt_q, err_cnt_q;
  logic [BYTE_W-1:0] byte_cnt_q;
  logic [EMPTY_W:0]  beat_bytes;

  assign beat_in = in.line;
  assign accept  = in.valid && ready_q;
  assign pop     = out_valid_q && out.ready;

`ifdef PKT_LEN_CHECK_EN
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  logic [BEAT_W-1:0] beat_cnt_q, beat_idx;
  logic              trunc;

  // Position of the current beat within its packet, counting from SOP.
  assign beat_idx = beat_in.sop ? BEAT_W'(1) : beat_cnt_q + BEAT_W'(1);
  assign trunc    = fwd && !beat_in.eop && (beat_idx == BEAT_W'(MAX_BEATS));
  assign eop_eff  = beat_in.eop || trunc;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)  beat_cnt_q <= '0;
    else if (fwd)  beat_cnt_q <= beat_idx;
  end
`else
  logic unused_max_beats;
  assign unused_max_beats = (MAX_BEATS > 0);
  assign eop_eff          = beat_in.eop;
`endif

  // A truncated beat always has eop=0 on input, so gating empty with the
  // input eop also yields empty=0 for forced-EOP beats.
  always_comb begin
    push_line       = beat_in;
    push_line.eop   = eop_eff;
    push_line.empty = beat_in.eop ? beat_in.empty : '0;
  end

  // ---------------------------------------------------------------------------
  // Framing FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset_n) begin
    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample pre-edge values regardless of process evaluation order.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves the
    // signal unassigned and infers a latch.
    state_d = state_q;
    if (fwd) state_d = eop_eff ? S_IDLE : S_IN_PKT;
`ifdef PKT_LEN_CHECK_EN
    if (trunc) state_d = S_DISCARD;
    else if (accept && state_q == S_DISCARD && !beat_in.sop && beat_in.eop)
      state_d = S_IDLE;
`endif
  end

  always_comb begin
    fwd     = 1'b0;
    err_inc = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          fwd     = beat_in.sop;
          err_inc = !beat_in.sop;
        end
        S_IN_PKT: begin
          // SOP here means the previous packet never saw its EOP.
          fwd     = 1'b1;
          err_inc = beat_in.sop;
        end
`ifdef PKT_LEN_CHECK_EN
        S_DISCARD: begin
          fwd     = beat_in.sop;
          err_inc = beat_in.sop;
        end
`endif
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  assign occ_d = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(fwd) - 2'(pop);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: payload registers are reset as well so out.line is a known
      // value straight out of reset rather than X.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      if (pop) begin
        if (skid_valid_q) begin
          out_q        <= skid_q;
          skid_valid_q <= fwd;
          if (fwd) skid_q <= push_line;
        end else begin
          out_valid_q <= fwd;
          if (fwd) out_q <= push_line;
        end
      end else if (fwd) begin
        // ready_q guarantees a free slot whenever fwd is set.
        if (!out_valid_q) begin
          out_valid_q <= 1'b1;
          out_q       <= push_line;
        end else begin
          skid_valid_q <= 1'b1;
          skid_q       <= push_line;
        end
      end
      ready_q <= (occ_d != 2'd2);
    end
  end

  assign in.ready  = ready_q;
  assign out.valid = out_valid_q;
  assign out.line  = out_q;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  assign beat_bytes = out_q.eop ? (EMPTY_W+1)'(BYTES) - {1'b0, out_q.empty}
                                : (EMPTY_W+1)'(BYTES);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (pop) begin
        byte_cnt_q <= byte_cnt_q + BYTE_W'(beat_bytes);
        if (out_q.eop && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
      if (err_inc && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

`ifdef PKT_LEN_CHECK_EN
  logic [CNT_W-1:0] len_err_cnt_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)
      len_err_cnt_q <= '0;
    else if (trunc && len_err_cnt_q != '1)
      len_err_cnt_q <= len_err_cnt_q + CNT_W'(1);
  end

  assign len_err_cnt = len_err_cnt_q;
`else
  assign len_err_cnt = '0;
`endif

  assign pkt_cnt  = pkt_cnt_q;
  assign byte_cnt = byte_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule
